// File: rtl/text_writer.sv
// ---------------------------------------------------------------------------
// text_writer
//
// Turns a stream of ASCII bytes into writes to a character VRAM that holds
// a text screen of ROWS x COLS visible cells. The VRAM address layout is
// {row[4:0], col[5:0]}, which matches the display reader, so every row
// owns 64 cells even when fewer than 64 are visible.
//
// After reset the whole 2048-cell VRAM is filled with spaces. The block then
// accepts bytes. Printable bytes are drawn at the cursor and advance it.
// LF, and running off the right edge, move the cursor to column 0 of the
// next row (wrapping to row 0) and blank that row before more input is
// taken. CR returns the cursor to column 0. Other control bytes are consumed
// silently.
//
// Build option:
//   TEXT_WRITER_BACKSPACE_EN - when defined, 0x08 steps the cursor one
//                              column left and blanks that cell. When the
//                              cursor is already in column 0 it does
//                              nothing. When the macro is undefined, 0x08
//                              is an ordinary ignored control byte.
//
// Parameters:
//   COLS  visible text columns per row (1..64)
//   ROWS  visible text rows (1..32)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    a character byte is offered on in_data
//   in_data     character byte (ASCII)
//   in_ready    the byte is taken on this cycle; depends only on state
//   vram_waddr  registered VRAM write address {row, col}
//   vram_wdata  registered VRAM write data
//   vram_we     registered VRAM write strobe
//   cur_row     cursor row, always 0..ROWS-1
//   cur_col     cursor column, always 0..COLS-1
// ---------------------------------------------------------------------------
module text_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic [4:0]  cur_row,
  output logic [5:0]  cur_col
);

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q,   cnt_d;
  logic [4:0]  row_q,   row_d;
  logic [5:0]  col_q,   col_d;
  logic [10:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q,    we_d;
  logic        newline;

  // 0x20..0x7E and the whole upper half (0x80..0xFF) are drawn as glyphs.
  function automatic logic is_printable(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) || b[7];
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state and write-port logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    newline = 1'b0;

    case (state_q)
      CLR_ALL: begin
        // Counter runs 0..2047 issuing writes; bit 11 set marks the extra
        // turnaround cycle that holds in_ready low one cycle past the last
        // write.
        if (!cnt_q[11]) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[10:0];
          wdata_d = SPACE;
          cnt_d   = cnt_q + 12'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end

      CLR_LINE: begin
        // All 64 physical cells of the row are blanked, not just the
        // visible ones; bit 6 marks the turnaround cycle.
        if (!cnt_q[6]) begin
          we_d    = 1'b1;
          waddr_d = {row_q, cnt_q[5:0]};
          wdata_d = SPACE;
          cnt_d   = cnt_q + 12'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            we_d    = 1'b1;
            waddr_d = {row_q, col_q};
            wdata_d = in_data;
            if (col_q == LAST_COL) begin
              newline = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else if (in_data == CH_LF) begin
            newline = 1'b1;
          end else if (in_data == CH_CR) begin
            col_d = '0;
`ifdef TEXT_WRITER_BACKSPACE_EN
          end else if ((in_data == 8'h08) && (col_q != 6'd0)) begin
            col_d   = col_q - 6'd1;
            we_d    = 1'b1;
            waddr_d = {row_q, col_q - 6'd1};
            wdata_d = SPACE;
`endif
          end
        end
      end

      default: begin
        state_d = CLR_ALL;
        cnt_d   = '0;
      end
    endcase

    // Shared by LF and by a glyph landing in the last column; the glyph
    // write (if any) is already in the output register, so the row clear
    // starts on the following cycle without colliding with it.
    if (newline) begin
      col_d   = '0;
      row_d   = next_row(row_q);
      state_d = CLR_LINE;
      cnt_d   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State, cursor and registered VRAM write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign vram_we    = we_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;

endmodule

// File: tb/tb_text_writer.sv
module tb_text_writer;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        in_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [4:0]  cur_row;
  logic [5:0]  cur_col;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  mrow     = 0;
  int  mcol     = 0;

  text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .cur_row    (cur_row),
    .cur_col    (cur_col)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [10:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int row);
    for (int c = 0; c < 64; c++) push(11'(row * 64 + c), 8'h20);
  endtask

  // Scoreboard: every VRAM write is popped against the expected queue.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (vram_we === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL vram_write unexpected: addr=%03h data=%02h, required no write",
                   vram_waddr, vram_wdata);
        end else begin
          e = exp_q.pop_front();
          if (vram_waddr !== e.a || vram_wdata !== e.d) begin
            n_fail++;
            $display("FAIL vram_write: addr=%03h data=%02h, required addr=%03h data=%02h",
                     vram_waddr, vram_wdata, e.a, e.d);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
        $fatal(1, "in_ready never rose");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > limit) begin
        $display("FAIL wait_ready_timeout: in_ready=%b, required 1 within %0d cycles", in_ready, limit);
        $fatal(1, "in_ready never rose");
      end
    end
  endtask

  // Reference model of the cursor: pushes the writes a byte must cause,
  // then offers the byte to the DUT.
  task automatic type_byte(input logic [7:0] b);
    logic nl;
    nl = 1'b0;
    if ((b >= 8'h20 && b <= 8'h7E) || b >= 8'h80) begin
      push(11'(mrow * 64 + mcol), b);
      if (mcol == COLS - 1) nl = 1'b1;
      else mcol++;
    end else if (b == 8'h0A) begin
      nl = 1'b1;
    end else if (b == 8'h0D) begin
      mcol = 0;
`ifdef TEXT_WRITER_BACKSPACE_EN
    end else if (b == 8'h08 && mcol > 0) begin
      mcol--;
      push(11'(mrow * 64 + mcol), 8'h20);
`endif
    end
    if (nl) begin
      mcol = 0;
      mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
      push_clear(mrow);
    end
    send(b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || vram_we !== 1'b0 || vram_waddr !== 11'd0 || vram_wdata !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b we=%b addr=%03h data=%02h, required all 0",
               in_ready, vram_we, vram_waddr, vram_wdata);
    end
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (vram_we !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: we=%b ready=%b, required 0 0", vram_we, in_ready);
    end
  endtask

  task automatic test_clr_all();
    int cyc;
    exp_q.delete();
    for (int i = 0; i < 2048; i++) push(11'(i), 8'h20);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_all_first: we=%b addr=%03h ready=%b, required 1 000 0",
               vram_we, vram_waddr, in_ready);
    end
    cyc = 1;
    while (in_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 2100) begin
        $display("FAIL clr_all_timeout: in_ready=%b after %0d cycles, required 1", in_ready, cyc);
        $fatal(1, "clear never finished");
      end
    end
    n_checks++;
    if (cyc != 2049) begin
      n_fail++;
      $display("FAIL clr_all_ready_latency: %0d cycles, required 2049", cyc);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clr_all_write_count: %0d writes missing, required 0", exp_q.size());
    end
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd0 || vram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_all_end: cursor (%0d,%0d) we=%b, required (0,0) we=0",
               cur_row, cur_col, vram_we);
    end
    mrow = 0;
    mcol = 0;
  endtask

  task automatic test_back_to_back();
    type_byte(8'h41);
    @(negedge clk);
    n_checks++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'h000 || vram_wdata !== 8'h41) begin
      n_fail++;
      $display("FAIL b2b_A: we=%b addr=%03h data=%02h, required 1 000 41",
               vram_we, vram_waddr, vram_wdata);
    end
    type_byte(8'h42);
    @(negedge clk);
    n_checks++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'h001 || vram_wdata !== 8'h42) begin
      n_fail++;
      $display("FAIL b2b_B: we=%b addr=%03h data=%02h, required 1 001 42",
               vram_we, vram_waddr, vram_wdata);
    end
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd2) begin
      n_fail++;
      $display("FAIL b2b_cursor: (%0d,%0d), required (0,2)", cur_row, cur_col);
    end
  endtask

  task automatic test_line_wrap();
    int bad;
    type_byte(8'h0D);
    n_checks++;
    if (cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL wrap_cr: col=%0d, required 0", cur_col);
    end
    for (int i = 0; i < 40; i++) type_byte(8'h58);
    @(negedge clk);
    n_checks++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'h027 || vram_wdata !== 8'h58 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_40th: we=%b addr=%03h data=%02h ready=%b, required 1 027 58 0",
               vram_we, vram_waddr, vram_wdata, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || vram_we !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_clr_line: %0d cycles with ready=1 or we=0, required 0", bad);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || vram_we !== 1'b0 || cur_row !== 5'd1 || cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL wrap_end: ready=%b we=%b cursor (%0d,%0d), required 1 0 (1,0)",
               in_ready, vram_we, cur_row, cur_col);
    end
  endtask

  task automatic test_newline_wrap();
    for (int i = 0; i < 28; i++) type_byte(8'h0A);
    for (int i = 0; i < 5; i++) type_byte(8'(8'h61 + i));
    n_checks++;
    if (cur_row !== 5'd29 || cur_col !== 6'd5) begin
      n_fail++;
      $display("FAIL nl_setup: (%0d,%0d), required (29,5)", cur_row, cur_col);
    end
    type_byte(8'h0A);
    wait_ready(200);
    @(negedge clk);
    #1;
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL nl_wrap_cursor: (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL nl_wrap_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_control_bytes();
    for (int i = 0; i < 3; i++) type_byte(8'h0A);
    for (int i = 0; i < 7; i++) type_byte(8'h30 + 8'(i));
    type_byte(8'h0D);
    n_checks++;
    if (cur_row !== 5'd3 || cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL cr_cursor: (%0d,%0d), required (3,0)", cur_row, cur_col);
    end
    @(negedge clk);
    n_checks++;
    if (vram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL cr_no_write: we=%b, required 0", vram_we);
    end
    for (int i = 0; i < 7; i++) type_byte(8'h30 + 8'(i));
    type_byte(8'h01);
    type_byte(8'h7F);
    n_checks++;
    if (cur_row !== 5'd3 || cur_col !== 6'd7) begin
      n_fail++;
      $display("FAIL ctrl_ignored: (%0d,%0d), required (3,7)", cur_row, cur_col);
    end
    type_byte(8'h08);
`ifdef TEXT_WRITER_BACKSPACE_EN
    n_checks++;
    if (cur_row !== 5'd3 || cur_col !== 6'd6) begin
      n_fail++;
      $display("FAIL bs_cursor: (%0d,%0d), required (3,6)", cur_row, cur_col);
    end
    @(negedge clk);
    n_checks++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'h0C6 || vram_wdata !== 8'h20) begin
      n_fail++;
      $display("FAIL bs_write: we=%b addr=%03h data=%02h, required 1 0c6 20",
               vram_we, vram_waddr, vram_wdata);
    end
    type_byte(8'h0D);
    type_byte(8'h08);
    n_checks++;
    if (cur_row !== 5'd3 || cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL bs_col0_cursor: (%0d,%0d), required (3,0)", cur_row, cur_col);
    end
`else
    n_checks++;
    if (cur_row !== 5'd3 || cur_col !== 6'd7) begin
      n_fail++;
      $display("FAIL bs_ignored: (%0d,%0d), required (3,7)", cur_row, cur_col);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (vram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_no_write: we=%b, required 0", vram_we);
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ctrl_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (cur_row !== 5'd0 || cur_col !== 6'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_reset: cursor (%0d,%0d) ready=%b, required (0,0) 0", cur_row, cur_col, in_ready);
    end
    exp_q.delete();
    for (int i = 0; i < 2048; i++) push(11'(i), 8'h20);
    @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(posedge clk);
    #6;
    reset = 1'b1;
    #1;
    n_checks++;
    if (vram_we !== 1'b0 || vram_waddr !== 11'd0 || vram_wdata !== 8'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_reset: we=%b addr=%03h data=%02h ready=%b, required all 0",
               vram_we, vram_waddr, vram_wdata, in_ready);
    end
    exp_q.delete();
    for (int i = 0; i < 2048; i++) push(11'(i), 8'h20);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'd0) begin
      n_fail++;
      $display("FAIL midclr_restart: we=%b addr=%03h, required 1 000", vram_we, vram_waddr);
    end
    wait_ready(2100);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || cur_row !== 5'd0 || cur_col !== 6'd0) begin
      n_fail++;
      $display("FAIL midclr_complete: %0d writes missing cursor (%0d,%0d), required 0 (0,0)",
               exp_q.size(), cur_row, cur_col);
    end
    mrow = 0;
    mcol = 0;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clr_all();
    test_back_to_back();
    test_line_wrap();
    test_newline_wrap();
    test_control_bytes();
    test_mid_reset();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLS, default 40, number of visible text columns per row (1..64).
REQ-002 Parameter ROWS, default 30, number of visible text rows (1..32).
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  the character byte on in_data is offered.
REQ-006 Port in_data  input  8  the character byte, ASCII.
REQ-007 Port in_ready  output  1  the block accepts in_data this cycle.
REQ-008 Port vram_waddr  output  11  VRAM write address {row[4:0], col[5:0]}, the same layout the display reader uses.
REQ-009 Port vram_wdata  output  8  VRAM write data.
REQ-010 Port vram_we  output  1  VRAM write strobe, one write per cycle when high.
REQ-011 Port cur_row  output  5  current cursor row.
REQ-012 Port cur_col  output  6  current cursor column.

Function
REQ-013 A byte is accepted only on a cycle where in_valid and in_ready are both high; in_ready does not depend combinationally on in_valid.
REQ-014 The state machine has three states: CLR_ALL (clears the whole screen), IDLE (in_ready=1), and CLR_LINE (clears one row); in_ready=0 in both clear states.
REQ-015 In CLR_ALL, the block writes 0x20 to addresses 0..2047, one per cycle in ascending order, then enters IDLE with the cursor at (0,0).
REQ-016 An accepted printable byte (0x20..0x7E or 0x80..0xFF) is written to {cur_row,cur_col}, with vram_we high on the cycle after acceptance; cur_col then increments.
REQ-017 If a printable byte is accepted at cur_col==COLS-1, the byte is written and a newline action follows.
REQ-018 Newline action: cur_col=0; cur_row increments, wrapping from ROWS-1 to 0; the state goes to CLR_LINE.
REQ-019 In CLR_LINE, the block writes 0x20 to {new_row, 0..63}, one per cycle (64 cycles), then returns to IDLE; in_ready goes high on the cycle after the final write.
REQ-020 An accepted 0x0A performs the newline action with no glyph write.
REQ-021 An accepted 0x0D sets cur_col=0 with no write and no state change.
REQ-022 All other accepted bytes 0x00..0x1F and 0x7F are consumed with no write and no cursor change, unless REQ-035 applies.
REQ-023 In IDLE, back-to-back accepts are sustained at one byte per cycle.
REQ-024 vram_waddr, vram_wdata and vram_we are registered outputs.
REQ-025 vram_we is low on every cycle that performs no write.
REQ-026 cur_row and cur_col always hold values in 0..ROWS-1 and 0..COLS-1 respectively.

Reset
REQ-027 While reset is high, the block sets in_ready=0, vram_we=0, vram_waddr=0, vram_wdata=0, cur_row=0 and cur_col=0, and the clear counter to 0.
REQ-028 On reset release, the block enters CLR_ALL, and the first write to address 0 occurs on the first clock edge after release.
REQ-029 Reset asserted during any state, including mid-CLR_ALL or mid-CLR_LINE, aborts that operation, and the full CLR_ALL sequence restarts.
REQ-030 After reset release, in_ready first goes high exactly 2049 cycles later.

Configuration
REQ-031 Macro TEXT_WRITER_BACKSPACE_EN selects whether backspace handling is compiled in.
REQ-032 With TEXT_WRITER_BACKSPACE_EN defined, an accepted 0x08 at cur_col>0 decrements cur_col and writes 0x20 to the new position one cycle later.
REQ-033 With TEXT_WRITER_BACKSPACE_EN defined, an accepted 0x08 at cur_col==0 has no effect and causes no write.
REQ-034 Without TEXT_WRITER_BACKSPACE_EN, 0x08 is handled per REQ-022.
REQ-035 REQ-032 and REQ-033 are the only exception to REQ-022.

Verification
REQ-036 Release reset -> exactly 2048 writes of 0x20 at addresses 0..2047, then in_ready=1 with cursor (0,0).
REQ-037 Send "AB" back-to-back -> writes 0x41 at 0x000 and 0x42 at 0x001 on consecutive cycles; cur_col=2.
REQ-038 Send 40 'X' bytes from col 0, row 0 -> the 40th write goes to 0x027; then 64 writes of 0x20 at 0x040..0x07F, in_ready=0 throughout; then cursor (1,0).
REQ-039 Cursor at (29,5), send 0x0A -> 0x20 written to 0x000..0x03F; cursor (0,0); no glyph write.
REQ-040 Send 0x0D at (3,7) -> cursor (3,0) with no write; with TEXT_WRITER_BACKSPACE_EN, 0x08 at (3,7) -> 0x20 written to 0x0C6 and cursor (3,6).
REQ-041 Assert reset at clear count 1000 -> outputs zero immediately; after release, writes restart at address 0.
